// File: rtl/slot_round_ctrl_if.sv
// Slot round controller bus: front-end controls in, credit/reel/result status out.
//   clear, load, load_value, start : requests from the KEY/SW front end
//   credits, reel0..2              : credit balance and reel positions
//   busy, win, triple, lose        : round status and latched result flags
//   no_credit                      : one-cycle pulse, start rejected on empty credit
interface slot_round_ctrl_if #(
  parameter int unsigned CREDIT_W = 5
);
  logic                clear;
  logic                load;
  logic [CREDIT_W-1:0] load_value;
  logic                start;
  logic [CREDIT_W-1:0] credits;
  logic [2:0]          reel0;
  logic [2:0]          reel1;
  logic [2:0]          reel2;
  logic                busy;
  logic                win;
  logic                triple;
  logic                lose;
  logic                no_credit;

  modport master (
    output clear, load, load_value, start,
    input  credits, reel0, reel1, reel2, busy, win, triple, lose, no_credit
  );

  modport slave (
    input  clear, load, load_value, start,
    output credits, reel0, reel1, reel2, busy, win, triple, lose, no_credit
  );
endinterface

// File: rtl/slot_round_ctrl.sv
// Slot machine round sequencer: owns the credit register, charges a bet per
// accepted start, spins three reels, stops them in turn, evaluates the match
// and applies a saturating payout.
//   CLOCK_50 : system clock, rising edge
//   resetn   : asynchronous active-low reset
//   bus      : slot_round_ctrl_if slave modport (requests in, status out)
module slot_round_ctrl #(
  parameter int unsigned CREDIT_W    = 5,
  parameter int unsigned SPIN_CYCLES = 16,
  parameter int unsigned STOP_GAP    = 8,
  parameter int unsigned PAY_PAIR    = 2,
  parameter int unsigned PAY_TRIPLE  = 8
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  slot_round_ctrl_if.slave   bus
);

  localparam int unsigned CNT_MAX = (SPIN_CYCLES > STOP_GAP) ? SPIN_CYCLES : STOP_GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned SUM_W   = 32;
  localparam logic [CREDIT_W-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPIN  = 3'd1,
    STOP1 = 3'd2,
    STOP2 = 3'd3,
    EVAL  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [2:0]          reel0_q, reel0_d;
  logic [2:0]          reel1_q, reel1_d;
  logic [2:0]          reel2_q, reel2_d;
  logic [2:0]          frz_q, frz_d;
  logic                busy_q, busy_d;
  logic                win_q, win_d;
  logic                triple_q, triple_d;
  logic                lose_q, lose_d;
  logic                no_credit_q, no_credit_d;
  logic [SUM_W-1:0]    sum_c;
  logic                is_triple_c;
  logic                is_pair_c;

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      credits_q   <= '0;
      reel0_q     <= '0;
      reel1_q     <= '0;
      reel2_q     <= '0;
      frz_q       <= '0;
      busy_q      <= 1'b0;
      win_q       <= 1'b0;
      triple_q    <= 1'b0;
      lose_q      <= 1'b0;
      no_credit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      credits_q   <= credits_d;
      reel0_q     <= reel0_d;
      reel1_q     <= reel1_d;
      reel2_q     <= reel2_d;
      frz_q       <= frz_d;
      busy_q      <= busy_d;
      win_q       <= win_d;
      triple_q    <= triple_d;
      lose_q      <= lose_d;
      no_credit_q <= no_credit_d;
    end
  end

  // Match detection on the settled reel values seen in EVAL
  always_comb begin
    is_triple_c = (reel0_q == reel1_q) && (reel1_q == reel2_q);
    is_pair_c   = !is_triple_c &&
                  ((reel0_q == reel1_q) || (reel1_q == reel2_q) || (reel0_q == reel2_q));
  end

  // Next-state, counter, credit and flag logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    credits_d   = credits_q;
    frz_d       = frz_q;
    busy_d      = busy_q;
    win_d       = win_q;
    triple_d    = triple_q;
    lose_d      = lose_q;
    no_credit_d = 1'b0;
    sum_c       = SUM_W'(credits_q);

    // Reels free-run in every state, including IDLE, until frozen
    reel0_d = frz_q[0] ? reel0_q : reel0_q + 3'd1;
    reel1_d = frz_q[1] ? reel1_q : reel1_q + 3'd3;
    reel2_d = frz_q[2] ? reel2_q : reel2_q + 3'd5;

    if (bus.clear) begin
      // Abort: freeze flags untouched so frozen reels stay put
      state_d   = IDLE;
      cnt_d     = '0;
      credits_d = '0;
      busy_d    = 1'b0;
      win_d     = 1'b0;
      triple_d  = 1'b0;
      lose_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            credits_d = bus.load_value;
          end else if (bus.start) begin
            if (credits_q != '0) begin
              credits_d = credits_q - CREDIT_W'(1);
              state_d   = SPIN;
              cnt_d     = '0;
              frz_d     = '0;
              busy_d    = 1'b1;
              win_d     = 1'b0;
              triple_d  = 1'b0;
              lose_d    = 1'b0;
            end else begin
              no_credit_d = 1'b1;
            end
          end
        end
        SPIN: begin
          if (cnt_q == CNT_W'(SPIN_CYCLES - 1)) begin
            cnt_d    = '0;
            frz_d[0] = 1'b1;
            state_d  = STOP1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STOP1: begin
          if (cnt_q == CNT_W'(STOP_GAP - 1)) begin
            cnt_d    = '0;
            frz_d[1] = 1'b1;
            state_d  = STOP2;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STOP2: begin
          if (cnt_q == CNT_W'(STOP_GAP - 1)) begin
            cnt_d    = '0;
            frz_d[2] = 1'b1;
            state_d  = EVAL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        EVAL: begin
          // Wide sum so the saturation compare cannot wrap
          if (is_triple_c) begin
            sum_c    = SUM_W'(credits_q) + SUM_W'(PAY_TRIPLE);
            win_d    = 1'b1;
            triple_d = 1'b1;
          end else if (is_pair_c) begin
            sum_c = SUM_W'(credits_q) + SUM_W'(PAY_PAIR);
            win_d = 1'b1;
          end else begin
            lose_d = 1'b1;
          end
          credits_d = (sum_c > SUM_W'(CMAX)) ? CMAX : CREDIT_W'(sum_c);
          state_d   = IDLE;
          busy_d    = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.credits   = credits_q;
  assign bus.reel0     = reel0_q;
  assign bus.reel1     = reel1_q;
  assign bus.reel2     = reel2_q;
  assign bus.busy      = busy_q;
  assign bus.win       = win_q;
  assign bus.triple    = triple_q;
  assign bus.lose      = lose_q;
  assign bus.no_credit = no_credit_q;

endmodule

// File: tb/tb_slot_round_ctrl.sv
// Directed self-checking bench for slot_round_ctrl (default parameters).
module tb_slot_round_ctrl;

  localparam int unsigned CREDIT_W = 5;
  // Edges from start acceptance to the EVAL update
  localparam int unsigned ROUND_LAT = 16 + 2 * 8 + 1;

  logic CLOCK_50;
  logic resetn;
  int   total;
  int   bad;

  slot_round_ctrl_if #(.CREDIT_W(CREDIT_W)) bus ();

  slot_round_ctrl #(
    .CREDIT_W    (CREDIT_W),
    .SPIN_CYCLES (16),
    .STOP_GAP    (8),
    .PAY_PAIR    (2),
    .PAY_TRIPLE  (8)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus.slave)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reset, then release so the first edge after release captures the load
  // (and optionally a start in the same cycle). Returns at the following negedge.
  task automatic rst_load(input int val, input bit with_start);
    @(negedge CLOCK_50);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    resetn         = 1'b1;
    bus.load       = 1'b1;
    bus.load_value = CREDIT_W'(val);
    bus.start      = with_start;
    @(negedge CLOCK_50);
    bus.load  = 1'b0;
    bus.start = 1'b0;
  endtask

  // Start accepted at edge k counted from reset release (k>=2); run to EVAL
  task automatic play(input int k, input int cred0, input string tag);
    repeat (k - 2) @(negedge CLOCK_50);
    bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    chk({tag, "_busy_start"}, int'(bus.busy), 1);
    chk({tag, "_bet"}, int'(bus.credits), cred0 - 1);
    repeat (ROUND_LAT) @(negedge CLOCK_50);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    resetn         = 1'b0;
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.start      = 1'b0;

    // Async reset mid-round drops every output at once
    rst_load(10, 1'b0);
    bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    chk("pre_rst_busy", int'(bus.busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_credits", int'(bus.credits), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_reels", int'({bus.reel0, bus.reel1, bus.reel2}), 0);
    chk("rst_flags", int'({bus.win, bus.triple, bus.lose, bus.no_credit}), 0);

    // Load with a simultaneous start: start ignored
    rst_load(10, 1'b1);
    chk("load_credits", int'(bus.credits), 10);
    chk("load_start_busy", int'(bus.busy), 0);
    @(negedge CLOCK_50);
    chk("load_start_idle", int'(bus.busy), 0);

    // Triple: start at edge 8 -> reels 0,0,0
    rst_load(10, 1'b0);
    play(8, 10, "tri");
    chk("tri_reels", int'({bus.reel0, bus.reel1, bus.reel2}), 0);
    chk("tri_credits", int'(bus.credits), 17);
    chk("tri_win", int'(bus.win), 1);
    chk("tri_triple", int'(bus.triple), 1);
    chk("tri_lose", int'(bus.lose), 0);
    chk("tri_busy_end", int'(bus.busy), 0);

    // Pair: start at edge 10 -> reels 2,6,2
    rst_load(10, 1'b0);
    play(10, 10, "pair");
    chk("pair_r0", int'(bus.reel0), 2);
    chk("pair_r1", int'(bus.reel1), 6);
    chk("pair_r2", int'(bus.reel2), 2);
    chk("pair_credits", int'(bus.credits), 11);
    chk("pair_win", int'(bus.win), 1);
    chk("pair_triple", int'(bus.triple), 0);

    // Loss: start at edge 9 -> reels 1,3,5
    rst_load(10, 1'b0);
    play(9, 10, "loss");
    chk("loss_r0", int'(bus.reel0), 1);
    chk("loss_r1", int'(bus.reel1), 3);
    chk("loss_r2", int'(bus.reel2), 5);
    chk("loss_credits", int'(bus.credits), 9);
    chk("loss_lose", int'(bus.lose), 1);
    chk("loss_win", int'(bus.win), 0);

    // Load leaves result flags alone
    bus.load       = 1'b1;
    bus.load_value = CREDIT_W'(9);
    @(negedge CLOCK_50);
    bus.load = 1'b0;
    chk("load_keeps_lose", int'(bus.lose), 1);

    // Abort in STOP1 with clear, then start on empty credit
    bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    chk("abort_bet", int'(bus.credits), 8);
    chk("abort_lose_cleared", int'(bus.lose), 0);
    repeat (20) @(negedge CLOCK_50);
    chk("abort_busy_pre", int'(bus.busy), 1);
    bus.clear = 1'b1;
    @(negedge CLOCK_50);
    bus.clear = 1'b0;
    chk("abort_credits", int'(bus.credits), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_flags", int'({bus.win, bus.triple, bus.lose}), 0);
    repeat (2) @(negedge CLOCK_50);
    bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    chk("abort_no_credit", int'(bus.no_credit), 1);
    chk("abort_nc_busy", int'(bus.busy), 0);
    @(negedge CLOCK_50);
    chk("abort_nc_pulse", int'(bus.no_credit), 0);

    // Saturation: 30 - 1 + 8 clamps to 31
    rst_load(30, 1'b0);
    play(8, 30, "sat");
    chk("sat_credits", int'(bus.credits), 31);
    chk("sat_triple", int'(bus.triple), 1);

    // Empty: start with zero credit after reset
    rst_load(0, 1'b0);
    bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    chk("empty_no_credit", int'(bus.no_credit), 1);
    chk("empty_busy", int'(bus.busy), 0);
    chk("empty_credits", int'(bus.credits), 0);
    @(negedge CLOCK_50);
    chk("empty_pulse_end", int'(bus.no_credit), 0);
    chk("empty_still_idle", int'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
